sa_axi_txn_scheduler: RTL and testbench

// Sequences and shares the single-beat AXI4 master (mode/addra/addrb/wdata/rdata, init pulse, txn_done) between
// a load client (off-chip -> on-chip buffer) and a store client (results -> off-chip). Each client issues one block

---
 rtl/sa_axi_txn_scheduler_pkg.sv | 31 +++
 rtl/sa_axi_txn_scheduler_rr_arbiter2.sv | 40 ++++
 rtl/sa_axi_txn_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_sa_axi_txn_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_axi_txn_scheduler_pkg.sv
`default_nettype none
// =====================================================================
// sa_axi_pkg : master mode codes, scheduler states, word-stride helper
// Rev 1.0
// =====================================================================
package sa_axi_pkg;

   localparam logic [1:0] M_IDLE  = 2'b00;
   localparam logic [1:0] M_LOAD  = 2'b01;
   localparam logic [1:0] M_STORE = 2'b10;

   localparam logic CLIENT_LD = 1'b0;
   localparam logic CLIENT_ST = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_GRANT   = 3'd1,
      S_SETUP   = 3'd2,
      S_PULSE   = 3'd3,
      S_WAIT_LO = 3'd4,
      S_WAIT_HI = 3'd5,
      S_NEXT    = 3'd6,
      S_FINISH  = 3'd7
   } sched_state_t;

   function automatic int word_stride(input int data_width);
      return data_width / 8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sa_axi_txn_scheduler_rr_arbiter2.sv
`default_nettype none
// =====================================================================
// sa_rr_arbiter2 : two-way round-robin grant; on conflict the client
// not granted last wins.  Rev 1.0
// =====================================================================
module sa_rr_arbiter2
   import sa_axi_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       upd_id,
   output logic       grant_valid,
   output logic       grant_id
);

   logic r_last;

   // Reset as if store was served last so load wins the first conflict.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= CLIENT_ST;
      end else if (update) begin
         r_last <= upd_id;
      end
   end

   always_comb begin
      grant_valid = |req;
      grant_id    = CLIENT_LD;
      if (req == 2'b11) begin
         grant_id = ~r_last;
      end else if (req[1]) begin
         grant_id = CLIENT_ST;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sa_axi_txn_scheduler.sv
`default_nettype none
// =====================================================================
// sa_axi_txn_scheduler : splits load/store block commands into
// single-beat master transactions, round-robin shared.  Rev 1.0
// =====================================================================
module sa_axi_txn_scheduler
   import sa_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter int CNT_WIDTH  = 8,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ld_cmd_valid,
   output logic                  ld_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] ld_cmd_addr,
   input  logic [CNT_WIDTH-1:0]  ld_cmd_cnt,
   output logic [DATA_WIDTH-1:0] ld_rdata,
   output logic                  ld_rvalid,
   input  logic                  st_cmd_valid,
   output logic                  st_cmd_ready,
   input  logic [ADDR_WIDTH-1:0] st_cmd_addr,
   input  logic [CNT_WIDTH-1:0]  st_cmd_cnt,
   input  logic [DATA_WIDTH-1:0] st_wdata,
   input  logic                  st_wvalid,
   output logic                  st_wready,
   output logic                  cmd_done,
   output logic                  cmd_err,
   output logic                  busy,
   output logic [1:0]            m_mode,
   output logic [ADDR_WIDTH-1:0] m_addra,
   output logic [ADDR_WIDTH-1:0] m_addrb,
   output logic [DATA_WIDTH-1:0] m_wdata,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   output logic                  m_init_txn,
   input  logic                  m_txn_done,
   input  logic                  m_error
);

   localparam int STRIDE = word_stride(DATA_WIDTH);
   localparam int TW     = $clog2(TIMEOUT + 1);

   sched_state_t          r_state;
   logic                  r_sel;
   logic [ADDR_WIDTH-1:0] r_cur_addr;
   logic [CNT_WIDTH-1:0]  r_remaining;
   logic [TW-1:0]         r_timer;

   logic                  w_grant_valid;
   logic                  w_grant_id;
   logic                  w_arb_update;
   logic                  w_timeout;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic [ADDR_WIDTH-1:0] w_cmd_addr;
   logic [CNT_WIDTH-1:0]  w_cmd_cnt;
   logic [1:0]            w_mode;

   assign w_next_addr  = r_cur_addr + ADDR_WIDTH'(STRIDE);
   assign w_cmd_addr   = r_sel ? st_cmd_addr : ld_cmd_addr;
   assign w_cmd_cnt    = r_sel ? st_cmd_cnt  : ld_cmd_cnt;
   assign w_mode       = r_sel ? M_STORE     : M_LOAD;
   assign w_timeout    = (r_timer == TW'(TIMEOUT - 1));
   assign w_arb_update = (r_state == S_FINISH);

   sa_rr_arbiter2 u_arb (
      .clk         (clk),
      .reset       (reset),
      .req         ({st_cmd_valid, ld_cmd_valid}),
      .update      (w_arb_update),
      .upd_id      (r_sel),
      .grant_valid (w_grant_valid),
      .grant_id    (w_grant_id)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_sel        <= 1'b0;
         r_cur_addr   <= '0;
         r_remaining  <= '0;
         r_timer      <= '0;
         ld_cmd_ready <= 1'b0;
         st_cmd_ready <= 1'b0;
         ld_rdata     <= '0;
         ld_rvalid    <= 1'b0;
         st_wready    <= 1'b0;
         cmd_done     <= 1'b0;
         cmd_err      <= 1'b0;
         busy         <= 1'b0;
         m_mode       <= M_IDLE;
         m_addra      <= '0;
         m_addrb      <= '0;
         m_wdata      <= '0;
         m_init_txn   <= 1'b0;
      end else begin
         ld_rvalid  <= 1'b0;
         cmd_done   <= 1'b0;
         cmd_err    <= 1'b0;
         m_init_txn <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_grant_valid) begin
                  r_sel        <= w_grant_id;
                  ld_cmd_ready <= ~w_grant_id;
                  st_cmd_ready <= w_grant_id;
                  busy         <= 1'b1;
                  r_state      <= S_GRANT;
               end
            end

            S_GRANT: begin
               ld_cmd_ready <= 1'b0;
               st_cmd_ready <= 1'b0;
               r_cur_addr   <= w_cmd_addr;
               r_remaining  <= w_cmd_cnt;
               if (w_cmd_cnt == '0) begin
                  cmd_done <= 1'b1;
                  busy     <= 1'b0;
                  m_mode   <= M_IDLE;
                  r_state  <= S_FINISH;
               end else begin
                  m_mode <= w_mode;
                  if (r_sel) begin
                     m_addra   <= w_cmd_addr;
                     st_wready <= 1'b1;
                  end else begin
                     m_addrb <= w_cmd_addr;
                  end
                  r_state <= S_SETUP;
               end
            end

            // Store words wait here as long as the client withholds data.
            S_SETUP: begin
               if (!r_sel) begin
                  m_init_txn <= 1'b1;
                  r_state    <= S_PULSE;
               end else if (st_wvalid && st_wready) begin
                  m_wdata    <= st_wdata;
                  st_wready  <= 1'b0;
                  m_init_txn <= 1'b1;
                  r_state    <= S_PULSE;
               end
            end

            S_PULSE: begin
               r_timer <= '0;
               r_state <= S_WAIT_LO;
            end

            S_WAIT_LO: begin
               r_timer <= r_timer + 1'b1;
               if (!m_txn_done) begin
                  r_state <= S_WAIT_HI;
               end else if (w_timeout) begin
                  cmd_done <= 1'b1;
                  cmd_err  <= 1'b1;
                  busy     <= 1'b0;
                  m_mode   <= M_IDLE;
                  r_state  <= S_FINISH;
               end
            end

            S_WAIT_HI: begin
               r_timer <= r_timer + 1'b1;
               if (m_txn_done) begin
                  if (!r_sel) begin
                     ld_rdata  <= m_rdata;
                     ld_rvalid <= 1'b1;
                  end
                  if (m_error) begin
                     cmd_done <= 1'b1;
                     cmd_err  <= 1'b1;
                     busy     <= 1'b0;
                     m_mode   <= M_IDLE;
                     r_state  <= S_FINISH;
                  end else begin
                     r_state <= S_NEXT;
                  end
               end else if (w_timeout) begin
                  cmd_done <= 1'b1;
                  cmd_err  <= 1'b1;
                  busy     <= 1'b0;
                  m_mode   <= M_IDLE;
                  r_state  <= S_FINISH;
               end
            end

            // Address wraps modulo 2^ADDR_WIDTH without complaint.
            S_NEXT: begin
               r_cur_addr  <= w_next_addr;
               r_remaining <= r_remaining - 1'b1;
               if (r_remaining == CNT_WIDTH'(1)) begin
                  cmd_done <= 1'b1;
                  busy     <= 1'b0;
                  m_mode   <= M_IDLE;
                  r_state  <= S_FINISH;
               end else begin
                  if (r_sel) begin
                     m_addra   <= w_next_addr;
                     st_wready <= 1'b1;
                  end else begin
                     m_addrb <= w_next_addr;
                  end
                  r_state <= S_SETUP;
               end
            end

            S_FINISH: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sa_axi_txn_scheduler.sv
`default_nettype none
// =====================================================================
// tb_sa_axi_txn_scheduler : vector table, directed corner sequences and
// random commands against a behavioural single-beat master.  Rev 1.0
// =====================================================================
module tb_sa_axi_txn_scheduler;

   localparam int TO     = 1024;
   localparam int STRIDE = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         ld_cmd_valid = 1'b0, ld_cmd_ready;
   logic [31:0]  ld_cmd_addr = '0;
   logic [7:0]   ld_cmd_cnt = '0;
   logic [127:0] ld_rdata;
   logic         ld_rvalid;
   logic         st_cmd_valid = 1'b0, st_cmd_ready;
   logic [31:0]  st_cmd_addr = '0;
   logic [7:0]   st_cmd_cnt = '0;
   logic [127:0] st_wdata = '0;
   logic         st_wvalid = 1'b0, st_wready;
   logic         cmd_done, cmd_err, busy;
   logic [1:0]   m_mode;
   logic [31:0]  m_addra, m_addrb;
   logic [127:0] m_wdata;
   logic [127:0] m_rdata = '0;
   logic         m_init_txn;
   logic         m_txn_done = 1'b1;
   logic         m_error = 1'b0;

   sa_axi_txn_scheduler #(
      .ADDR_WIDTH(32), .DATA_WIDTH(128), .CNT_WIDTH(8), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .ld_cmd_valid(ld_cmd_valid), .ld_cmd_ready(ld_cmd_ready),
      .ld_cmd_addr(ld_cmd_addr), .ld_cmd_cnt(ld_cmd_cnt),
      .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
      .st_cmd_valid(st_cmd_valid), .st_cmd_ready(st_cmd_ready),
      .st_cmd_addr(st_cmd_addr), .st_cmd_cnt(st_cmd_cnt),
      .st_wdata(st_wdata), .st_wvalid(st_wvalid), .st_wready(st_wready),
      .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy),
      .m_mode(m_mode), .m_addra(m_addra), .m_addrb(m_addrb),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_init_txn(m_init_txn),
      .m_txn_done(m_txn_done), .m_error(m_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Master model configuration and observations.
   int           mdl_lat = 1, mdl_errw = 0, mdl_idx = 0, mdl_cnt = 0;
   bit           mdl_hang = 0, mdl_wait = 0, fall_pend = 0;
   logic [31:0]  mdl_addr = '0;
   logic [31:0]  txn_addr[$];
   logic [1:0]   txn_mode[$];
   logic [127:0] txn_wdata[$];
   logic [127:0] rv_data[$];
   int           cyc = 0, done_cnt = 0, init_cyc = 0, done_cyc = 0;
   bit           feed_en = 0, hs_flag = 0;
   int           feed_idx = 0;
   logic [31:0]  sbase = 32'hC0DE_0000;

   function automatic logic [127:0] mdata(input logic [31:0] a);
      return {a ^ 32'h5A5A_0001, ~a, a + 32'h0000_1234, a};
   endfunction

   function automatic logic [127:0] sgen(input int i);
      logic [31:0] w;
      w = sbase ^ (32'(i) * 32'h0001_0101);
      return {w, ~w, w + 32'd7, w ^ 32'hFFFF_0000};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Master model, monitors and store-data feeder, all on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         m_txn_done = 1'b1;
         m_error    = 1'b0;
         mdl_wait   = 0;
         fall_pend  = 0;
         hs_flag    = 0;
         st_wvalid  = 1'b0;
      end else begin
         if (!m_txn_done && !mdl_wait && !fall_pend && !mdl_hang) m_txn_done = 1'b1;
         if (mdl_wait) begin
            if (mdl_cnt <= 1) begin
               m_txn_done = 1'b1;
               m_error    = (mdl_idx == mdl_errw);
               m_rdata    = mdata(mdl_addr);
               mdl_wait   = 0;
            end else begin
               mdl_cnt--;
            end
         end
         if (fall_pend) begin
            m_txn_done = 1'b0;
            fall_pend  = 0;
            mdl_wait   = !mdl_hang;
            mdl_cnt    = mdl_lat;
         end
         if (m_init_txn) begin
            mdl_idx++;
            mdl_addr = (m_mode == 2'b10) ? m_addra : m_addrb;
            txn_addr.push_back(mdl_addr);
            txn_mode.push_back(m_mode);
            txn_wdata.push_back(m_wdata);
            fall_pend = 1;
            m_error   = 1'b0;
            init_cyc  = cyc;
         end
         if (ld_rvalid) rv_data.push_back(ld_rdata);
         if (cmd_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (hs_flag) feed_idx++;
         st_wdata  = sgen(feed_idx);
         st_wvalid = feed_en;
         hs_flag   = st_wvalid && st_wready;
      end
   end

   task automatic wait_done(input string nm, output bit err);
      bit seen;
      seen = 0;
      err  = 0;
      for (int t = 0; t < 3000; t++) begin
         if (cmd_done) begin
            seen = 1;
            err  = cmd_err;
            break;
         end
         tick();
      end
      chk({nm, "_done_seen"}, 128'(seen), 128'd1);
   endtask

   task automatic run_cmd(input bit st, input logic [31:0] a, input logic [7:0] n,
                          input int lat, input int errw, input bit hang, input int delay,
                          input bit exp_err, input int exp_words, input string nm);
      bit got, err;
      int nrv;
      logic [31:0] ea;
      txn_addr.delete(); txn_mode.delete(); txn_wdata.delete(); rv_data.delete();
      mdl_lat = lat; mdl_errw = errw; mdl_hang = hang; mdl_idx = 0; feed_idx = 0;
      feed_en = st && (delay == 0);
      if (st) begin
         st_cmd_addr = a; st_cmd_cnt = n; st_cmd_valid = 1'b1;
      end else begin
         ld_cmd_addr = a; ld_cmd_cnt = n; ld_cmd_valid = 1'b1;
      end
      got = 0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (st ? st_cmd_ready : ld_cmd_ready) begin
            got = 1;
            break;
         end
      end
      chk({nm, "_accept"}, 128'(got), 128'd1);
      if (got) chk({nm, "_busy_hi"}, 128'(busy), 128'd1);
      tick();
      ld_cmd_valid = 1'b0;
      st_cmd_valid = 1'b0;
      if (delay > 0) begin
         repeat (delay) tick();
         chk({nm, "_stall_no_txn"}, 128'(txn_addr.size()), 128'd0);
         chk({nm, "_stall_wready"}, 128'(st_wready), 128'd1);
         feed_en = 1;
      end
      wait_done(nm, err);
      chk({nm, "_err"}, 128'(err), 128'(exp_err));
      chk({nm, "_busy_lo"}, 128'(busy), 128'd0);
      tick();
      feed_en = 0;
      tick();
      chk({nm, "_words"}, 128'(txn_addr.size()), 128'(exp_words));
      for (int i = 0; i < txn_addr.size() && i < exp_words; i++) begin
         ea = a + 32'(i * STRIDE);
         chk({nm, "_addr"}, 128'(txn_addr[i]), 128'(ea));
         chk({nm, "_mode"}, 128'(txn_mode[i]), st ? 128'd2 : 128'd1);
         if (st) chk({nm, "_wdata"}, txn_wdata[i], sgen(i));
      end
      nrv = (st || hang) ? 0 : exp_words;
      chk({nm, "_rvalid_cnt"}, 128'(rv_data.size()), 128'(nrv));
      for (int i = 0; i < rv_data.size() && i < nrv; i++) begin
         ea = a + 32'(i * STRIDE);
         chk({nm, "_rdata"}, rv_data[i], mdata(ea));
      end
   endtask

   // Both clients request together; records grant order and checks words stay unmixed.
   task automatic arb_round(input bit exp_first, input string nm);
      bit err;
      int got;
      ld_cmd_addr = 32'h500; ld_cmd_cnt = 8'd1; ld_cmd_valid = 1'b1;
      st_cmd_addr = 32'h600; st_cmd_cnt = 8'd1; st_cmd_valid = 1'b1;
      mdl_lat = 1; mdl_errw = 0; mdl_hang = 0; feed_en = 1;
      for (int g = 0; g < 2; g++) begin
         txn_addr.delete(); txn_mode.delete(); txn_wdata.delete(); rv_data.delete();
         mdl_idx = 0; feed_idx = 0;
         got = 2;
         for (int t = 0; t < 20; t++) begin
            tick();
            if (ld_cmd_ready) begin got = 0; break; end
            if (st_cmd_ready) begin got = 1; break; end
         end
         chk({nm, "_grant"}, 128'(got), (g == 0) ? 128'(exp_first) : 128'(!exp_first));
         tick();
         if (got == 0) ld_cmd_valid = 1'b0;
         else if (got == 1) st_cmd_valid = 1'b0;
         else begin
            ld_cmd_valid = 1'b0;
            st_cmd_valid = 1'b0;
         end
         wait_done(nm, err);
         chk({nm, "_txn_cnt"}, 128'(txn_addr.size()), 128'd1);
         if (txn_mode.size() > 0)
            chk({nm, "_txn_mode"}, 128'(txn_mode[0]), (got == 1) ? 128'd2 : 128'd1);
         tick();
      end
      feed_en = 0;
      ld_cmd_valid = 1'b0;
      st_cmd_valid = 1'b0;
      tick();
   endtask

   typedef struct {
      bit          st;
      logic [31:0] addr;
      logic [7:0]  cnt;
      int          lat;
      int          errw;
      bit          exp_err;
      int          exp_words;
   } vec_t;

   vec_t vecs[7];

   initial begin
      bit          err;
      bit          rst_st;
      int          d0, dcyc;
      logic [31:0] ra;
      logic [7:0]  rn;

      vecs[0] = '{0, 32'h0000_0100, 8'd4, 2, 0, 0, 4};
      vecs[1] = '{1, 32'h0000_0040, 8'd3, 3, 0, 0, 3};
      vecs[2] = '{0, 32'hFFFF_FFF0, 8'd2, 1, 0, 0, 2};
      vecs[3] = '{0, 32'h0000_0200, 8'd5, 2, 2, 1, 2};
      vecs[4] = '{1, 32'h0000_1000, 8'd4, 1, 3, 1, 3};
      vecs[5] = '{0, 32'h0000_0000, 8'd0, 1, 0, 0, 0};
      vecs[6] = '{1, 32'h0000_0080, 8'd1, 4, 0, 0, 1};

      repeat (3) tick();
      chk("reset_flags", {ld_cmd_ready, st_cmd_ready, ld_rvalid, st_wready,
                          cmd_done, cmd_err, busy, m_init_txn, m_mode}, '0);
      chk("reset_ld_rdata", ld_rdata, '0);
      chk("reset_m_addra", 128'(m_addra), '0);
      reset = 1'b0;
      tick();

      arb_round(1'b0, "arb1");
      arb_round(1'b0, "arb2");
      run_cmd(0, 32'h0000_0800, 8'd1, 1, 0, 0, 0, 0, 1, "solo_load");
      arb_round(1'b1, "arb3");

      for (int v = 0; v < 7; v++)
         run_cmd(vecs[v].st, vecs[v].addr, vecs[v].cnt, vecs[v].lat, vecs[v].errw,
                 0, 0, vecs[v].exp_err, vecs[v].exp_words, $sformatf("vec%0d", v));

      run_cmd(1, 32'h0000_0040, 8'd3, 2, 0, 0, 10, 0, 3, "store_delay");

      // Zero-length command completes two cycles after valid, without a master transaction.
      txn_addr.delete();
      ld_cmd_addr = 32'h0000_0900; ld_cmd_cnt = 8'd0; ld_cmd_valid = 1'b1;
      tick();
      chk("cnt0_ready", 128'(ld_cmd_ready), 128'd1);
      tick();
      ld_cmd_valid = 1'b0;
      chk("cnt0_done", {cmd_done, cmd_err}, 128'b10);
      repeat (3) tick();
      chk("cnt0_no_txn", 128'(txn_addr.size()), 128'd0);

      run_cmd(0, 32'h0000_0300, 8'd2, 1, 0, 1, 0, 1, 1, "timeout");
      dcyc = done_cyc - init_cyc;
      chk("timeout_cycles", 128'(dcyc >= TO && dcyc <= TO + 4), 128'd1);
      mdl_hang = 0;
      repeat (3) tick();

      // Reset while the master is still working on the first word.
      txn_addr.delete(); rv_data.delete();
      mdl_lat = 20; mdl_errw = 0; mdl_idx = 0;
      ld_cmd_addr = 32'h0000_0700; ld_cmd_cnt = 8'd3; ld_cmd_valid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (ld_cmd_ready) break;
      end
      tick();
      ld_cmd_valid = 1'b0;
      for (int t = 0; t < 50; t++) begin
         if (txn_addr.size() > 0) break;
         tick();
      end
      repeat (4) tick();
      chk("rst_mid_busy", 128'(busy), 128'd1);
      d0 = done_cnt;
      reset = 1'b1;
      tick();
      rst_st = 1;
      reset = 1'b0;
      chk("rst_mid_flags", {ld_cmd_ready, st_cmd_ready, ld_rvalid, st_wready,
                            cmd_done, cmd_err, busy, m_init_txn, m_mode}, '0);
      chk("rst_mid_addrb", 128'(m_addrb), '0);
      repeat (30) tick();
      chk("rst_mid_no_done", 128'(done_cnt - d0), 128'd0);
      chk("rst_mid_no_rvalid", 128'(rv_data.size()), 128'd0);
      chk("rst_mid_txns", 128'(txn_addr.size()), 128'd1);
      if (rst_st) run_cmd(0, 32'h0000_0A00, 8'd2, 2, 0, 0, 0, 0, 2, "post_reset");

      for (int r = 0; r < 12; r++) begin
         ra    = $urandom & 32'hFFFF_FFF0;
         rn    = 8'($urandom_range(0, 6));
         sbase = $urandom;
         run_cmd(1'($urandom_range(0, 1)), ra, rn, $urandom_range(1, 5), 0, 0, 0, 0,
                 int'(rn), $sformatf("rnd%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
